// File: rtl/machine_timer.sv
// machine_timer: memory-mapped machine timer peripheral.
//
// A free-running 32-bit COUNT is compared with a programmable VALUE. On a match
// COUNT restarts at 0 and the sticky pend flag is set. The trap handler clears
// pend with a write-1-to-clear. bit 0 of int_sig_o is driven while pend & ie.
//
// Register map (addr_i[3:2]):
//   0x0 CTRL  [0] en, [1] ie, [2] pend (RO, W1C), [3] oneshot, [31:4] read 0
//   0x4 COUNT [31:0] RW
//   0x8 VALUE [31:0] RW
//   0xC PRESC [PRESC_W-1:0] RW with TIMER_PRESCALE_EN, otherwise reads 0
//
// Optional feature: define TIMER_PRESCALE_EN to add a tick prescaler.
//
// Ports:
//   clk        core clock, all logic on posedge
//   rst        synchronous active-low reset
//   req_i      bus request, one cycle per access
//   we_i       1 = write, 0 = read
//   addr_i     byte address, only [3:2] decoded
//   data_i     write data
//   data_o     registered read data, 0 when no ack
//   ack_o      one-cycle pulse one cycle after each request
//   int_sig_o  8'h01 while pend & ie, else 8'h00 (registered)

module machine_timer #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic [7:0]  int_sig_o
);

    localparam logic [7:0] IntNone  = 8'h00;
    localparam logic [7:0] IntTimer = 8'h01;

    logic [1:0]  sel;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_value;

    logic        en_q;
    logic        ie_q;
    logic        pend_q;
    logic        oneshot_q;
    logic [31:0] count_q;
    logic [31:0] value_q;

    logic        tick;
    logic        match;
    logic [31:0] rdata;

    assign sel      = addr_i[3:2];
    assign wr       = req_i & we_i;
    assign wr_ctrl  = wr & (sel == 2'd0);
    assign wr_count = wr & (sel == 2'd1);
    assign wr_value = wr & (sel == 2'd2);

`ifdef TIMER_PRESCALE_EN
    logic               wr_presc;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] pcnt_q;

    assign wr_presc = wr & (sel == 2'd3);
    assign tick     = en_q & (pcnt_q == presc_q);
`else
    assign tick     = en_q;
`endif

    // A COUNT write in a tick cycle suppresses the comparison entirely.
    assign match = tick & ~wr_count & (count_q == value_q);

    // Address bits outside [3:2] are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], PRESC_W[0]};

    always_comb begin
        rdata = '0;
        unique case (sel)
            2'd0: rdata = {28'b0, oneshot_q, pend_q, ie_q, en_q};
            2'd1: rdata = count_q;
            2'd2: rdata = value_q;
`ifdef TIMER_PRESCALE_EN
            2'd3: rdata = 32'(presc_q);
`else
            2'd3: rdata = '0;
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            pend_q    <= 1'b0;
            oneshot_q <= 1'b0;
            count_q   <= '0;
            value_q   <= '0;
            data_o    <= '0;
            ack_o     <= 1'b0;
            int_sig_o <= IntNone;
`ifdef TIMER_PRESCALE_EN
            presc_q   <= '0;
            pcnt_q    <= '0;
`endif
        end else begin
            // Reads see the register contents before this cycle's write.
            ack_o     <= req_i;
            data_o    <= req_i ? rdata : '0;
            int_sig_o <= (pend_q & ie_q) ? IntTimer : IntNone;

            if (wr_count) begin
                count_q <= data_i;
            end else if (tick) begin
                count_q <= (count_q == value_q) ? '0 : count_q + 32'd1;
            end

            if (wr_value) begin
                value_q <= data_i;
            end

            // Set beats a simultaneous W1C.
            if (match) begin
                pend_q <= 1'b1;
            end else if (wr_ctrl & data_i[2]) begin
                pend_q <= 1'b0;
            end

            // A CTRL write beats the oneshot auto-disable.
            if (wr_ctrl) begin
                en_q      <= data_i[0];
                ie_q      <= data_i[1];
                oneshot_q <= data_i[3];
            end else if (match & oneshot_q) begin
                en_q <= 1'b0;
            end

`ifdef TIMER_PRESCALE_EN
            if (wr_presc) begin
                presc_q <= data_i[PRESC_W-1:0];
            end

            if (wr_presc | wr_ctrl) begin
                pcnt_q <= '0;
            end else if (en_q) begin
                pcnt_q <= tick ? '0 : pcnt_q + PRESC_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: directed literal checks followed by
// randomized bus traffic compared each cycle against a behavioural model.

module tb_machine_timer;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [7:0]  int_sig;

    int n_cmp  = 0;
    int n_fail = 0;

    machine_timer #(.PRESC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .data_i    (wdata),
        .data_o    (rdata),
        .ack_o     (ack),
        .int_sig_o (int_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
`ifdef TIMER_PRESCALE_EN
    localparam bit HasPresc = 1'b1;
`else
    localparam bit HasPresc = 1'b0;
`endif

    logic        model_valid = 1'b0;
    logic        m_en, m_ie, m_pend, m_oneshot;
    logic [31:0] m_count, m_value, m_presc, m_pcnt;
    logic        exp_ack;
    logic [31:0] exp_data;
    logic [7:0]  exp_int;

    function automatic logic [31:0] m_read(input logic [1:0] s);
        case (s)
            2'd0:    return {28'b0, m_oneshot, m_pend, m_ie, m_en};
            2'd1:    return m_count;
            2'd2:    return m_value;
            default: return m_presc;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic        n_en, n_ie, n_pend, n_oneshot, t, hit;
        logic [31:0] n_count, n_value, n_presc, n_pcnt;
        logic [1:0]  s;
        if (!rst) begin
            model_valid <= 1'b1;
            {m_en, m_ie, m_pend, m_oneshot} <= 4'b0;
            m_count  <= 0;
            m_value  <= 0;
            m_presc  <= 0;
            m_pcnt   <= 0;
            exp_ack  <= 1'b0;
            exp_data <= 0;
            exp_int  <= 8'h00;
        end else begin
            s = addr[3:2];
            n_en = m_en; n_ie = m_ie; n_pend = m_pend; n_oneshot = m_oneshot;
            n_count = m_count; n_value = m_value; n_presc = m_presc; n_pcnt = m_pcnt;
            // Without a prescaler m_presc and m_pcnt stay 0, so a tick is every enabled cycle.
            t   = m_en && (m_pcnt == m_presc);
            hit = 1'b0;
            if (t && !(req && we && s == 2'd1)) begin
                if (m_count == m_value) begin
                    hit     = 1'b1;
                    n_count = 0;
                    n_pend  = 1'b1;
                    if (m_oneshot) n_en = 1'b0;
                end else begin
                    n_count = m_count + 1;
                end
            end
            if (m_en) n_pcnt = t ? 0 : m_pcnt + 1;
            if (req && we) begin
                case (s)
                    2'd0: begin
                        n_en = wdata[0];
                        n_ie = wdata[1];
                        n_oneshot = wdata[3];
                        if (wdata[2] && !hit) n_pend = 1'b0;
                        n_pcnt = 0;
                    end
                    2'd1: n_count = wdata;
                    2'd2: n_value = wdata;
                    default: if (HasPresc) begin
                        n_presc = wdata & 32'h0000_FFFF;
                        n_pcnt  = 0;
                    end
                endcase
            end
            exp_ack  <= req;
            exp_data <= req ? m_read(s) : 32'h0;
            exp_int  <= (m_pend && m_ie) ? 8'h01 : 8'h00;
            m_en <= n_en; m_ie <= n_ie; m_pend <= n_pend; m_oneshot <= n_oneshot;
            m_count <= n_count; m_value <= n_value; m_presc <= n_presc; m_pcnt <= n_pcnt;
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("ack", 32'(ack), 32'(exp_ack));
            check("data", rdata, exp_data);
            check("int_sig", 32'(int_sig), 32'(exp_int));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = {28'b0, a}; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd_check(input logic [3:0] a, input logic [31:0] exp, input string name);
        req = 1'b1; we = 1'b0; addr = {28'b0, a};
        @(negedge clk);
        req = 1'b0;
        check({name, "_ack"}, 32'(ack), 32'h1);
        check(name, rdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [1:0]  a;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = 0; wdata = 0;
        idle(3);
        rst = 1'b1;
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_int", 32'(int_sig), 32'h0);
        rd_check(4'h0, 32'h0, "reset_ctrl");
        rd_check(4'h4, 32'h0, "reset_count");
        rd_check(4'h8, 32'h0, "reset_value");
        rd_check(4'hC, 32'h0, "reset_presc");

        // Periodic match with VALUE=5.
        wr(4'h8, 32'd5);
        wr(4'h0, 32'h3);
        idle(5);
        rd_check(4'h4, 32'd5, "periodic_count5");
        check("periodic_int_lag", 32'(int_sig), 32'h0);
        rd_check(4'h0, 32'h7, "periodic_ctrl_pend");
        check("periodic_int", 32'(int_sig), 32'h1);

        // W1C in a non-match cycle, then in a match cycle.
        wr(4'h0, 32'h7);
        idle(1);
        check("w1c_int_clear", 32'(int_sig), 32'h0);
        rd_check(4'h0, 32'h3, "w1c_ctrl");
        idle(1);
        wr(4'h0, 32'h7);
        rd_check(4'h0, 32'h7, "w1c_on_match");

        // Oneshot.
        wr(4'h0, 32'h4);
        wr(4'h4, 32'h0);
        wr(4'h8, 32'd3);
        wr(4'h0, 32'hB);
        idle(4);
        rd_check(4'h0, 32'hE, "oneshot_ctrl");
        rd_check(4'h4, 32'h0, "oneshot_count");
        idle(3);
        rd_check(4'h4, 32'h0, "oneshot_held");

        // COUNT write on the match cycle.
        wr(4'h8, 32'd2);
        wr(4'h4, 32'h0);
        wr(4'h0, 32'h4);
        wr(4'h0, 32'h1);
        idle(2);
        wr(4'h4, 32'h100);
        rd_check(4'h4, 32'h100, "collide_count");
        rd_check(4'h0, 32'h1, "collide_pend");

        // Wrap from 0xFFFFFFFF.
        wr(4'h0, 32'h0);
        wr(4'h4, 32'hFFFF_FFFF);
        wr(4'h8, 32'd1);
        wr(4'h0, 32'h1);
        rd_check(4'h4, 32'hFFFF_FFFF, "wrap_max");
        rd_check(4'h4, 32'h0, "wrap_zero");
        rd_check(4'h4, 32'h1, "wrap_one");
        rd_check(4'h0, 32'h5, "wrap_pend");

        wr(4'h0, 32'h0);
        wr(4'h0, 32'h4);
`ifdef TIMER_PRESCALE_EN
        wr(4'h4, 32'h0);
        wr(4'h8, 32'd1);
        wr(4'hC, 32'd3);
        wr(4'h0, 32'h3);
        idle(3);
        rd_check(4'h4, 32'h0, "presc_count0");
        rd_check(4'h4, 32'h1, "presc_count1");
        idle(2);
        rd_check(4'h0, 32'h3, "presc_nopend");
        rd_check(4'h0, 32'h7, "presc_pend");
        rd_check(4'hC, 32'h3, "presc_reg");
`else
        wr(4'hC, 32'h5);
        rd_check(4'hC, 32'h0, "presc_absent");
`endif

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            req = ($urandom_range(0, 2) != 0);
            we  = ($urandom_range(0, 2) == 0);
            a   = 2'($urandom_range(0, 3));
            r   = $urandom;
            addr = {r[31:4], a, r[1:0]};
            wdata = $urandom;
            case (a)
                2'd0: if ($urandom_range(0, 3) != 0) wdata[0] = 1'b1;
                2'd1: wdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                                           : $urandom_range(0, 8);
                2'd2: wdata = $urandom_range(0, 8);
                default: wdata = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 3);
            endcase
            @(negedge clk);
        end
        rst = 1'b1; req = 1'b0; we = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
